// File: rtl/alu_flagged_n.sv
// Parametrised-width ALU with a registered result, a registered {O,N,C,Z} flag
// register and an En/Valid handshake; carry-in for ADC and rotates comes from the held C flag.
module alu_flagged_n #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             En,
    input  logic [3:0]       FunSel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] OutALU,
    output logic [3:0]       OutFlag,
    output logic             Valid
);

    // Handshake: an op is accepted on every rising CLK edge where En=1 and RST=0.
    // Its result and flags appear together one cycle later with Valid=1 for exactly
    // that cycle; there is no backpressure, so every accepted op produces one Valid pulse.

    localparam logic [3:0] OP_MOVA = 4'h0;
    localparam logic [3:0] OP_MOVB = 4'h1;
    localparam logic [3:0] OP_NOTA = 4'h2;
    localparam logic [3:0] OP_NOTB = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_ADC  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_LSL  = 4'hA;
    localparam logic [3:0] OP_LSR  = 4'hB;
    localparam logic [3:0] OP_ASL  = 4'hC;
    localparam logic [3:0] OP_ASR  = 4'hD;
    localparam logic [3:0] OP_ROL  = 4'hE;
    localparam logic [3:0] OP_ROR  = 4'hF;

    logic [WIDTH-1:0] out_alu_q, out_alu_d;
    logic [3:0]       flag_q, flag_d;
    logic             valid_q;

    logic [WIDTH-1:0] add_b;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             c_cur;
    logic             o_d, c_d;

    assign c_cur = flag_q[1];

    // One shared adder: SUB is A + ~B + 1, ADC injects the held carry.
    always_comb begin
        add_b = B;
        cin   = 1'b0;
        if (FunSel == OP_ADC) begin
            cin = c_cur;
        end else if (FunSel == OP_SUB) begin
            add_b = ~B;
            cin   = 1'b1;
        end
        sum = {1'b0, A} + {1'b0, add_b} + {{WIDTH{1'b0}}, cin};
    end

    always_comb begin
        out_alu_d = A;
        c_d       = flag_q[1];
        o_d       = flag_q[3];
        case (FunSel)
            OP_MOVA: out_alu_d = A;
            OP_MOVB: out_alu_d = B;
            OP_NOTA: out_alu_d = ~A;
            OP_NOTB: out_alu_d = ~B;
            OP_ADD, OP_ADC, OP_SUB: begin
                out_alu_d = sum[WIDTH-1:0];
                c_d       = sum[WIDTH];
                // With add_b already inverted for SUB, one overflow rule serves all three.
                o_d       = (A[WIDTH-1] == add_b[WIDTH-1]) &&
                            (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  out_alu_d = A & B;
            OP_OR:   out_alu_d = A | B;
            OP_XOR:  out_alu_d = A ^ B;
            OP_LSL: begin
                out_alu_d = {A[WIDTH-2:0], 1'b0};
                c_d       = A[WIDTH-1];
            end
            OP_LSR: begin
                out_alu_d = {1'b0, A[WIDTH-1:1]};
                c_d       = A[0];
            end
            OP_ASL: begin
                out_alu_d = {A[WIDTH-2:0], 1'b0};
                o_d       = A[WIDTH-1] ^ A[WIDTH-2];
            end
            OP_ASR:  out_alu_d = {A[WIDTH-1], A[WIDTH-1:1]};
            OP_ROL: begin
                out_alu_d = {A[WIDTH-2:0], c_cur};
                c_d       = A[WIDTH-1];
            end
            OP_ROR: begin
                out_alu_d = {c_cur, A[WIDTH-1:1]};
                c_d       = A[0];
            end
            default: out_alu_d = A;
        endcase
        flag_d = {o_d, out_alu_d[WIDTH-1], c_d, (out_alu_d == '0)};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_alu_q <= '0;
            flag_q    <= 4'b0000;
            valid_q   <= 1'b0;
        end else if (En) begin
            out_alu_q <= out_alu_d;
            flag_q    <= flag_d;
            valid_q   <= 1'b1;
        end else begin
            valid_q   <= 1'b0;
        end
    end

    assign OutALU  = out_alu_q;
    assign OutFlag = flag_q;
    assign Valid   = valid_q;

endmodule

// File: tb/tb_alu_flagged_n.sv
// Self-checking bench for alu_flagged_n at WIDTH=8: directed plan cases, an
// asynchronous mid-stream reset, and random back-to-back traffic through a scoreboard.
module tb_alu_flagged_n;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         En;
    logic [3:0]   FunSel;
    logic [W-1:0] A, B;
    logic [W-1:0] OutALU;
    logic [3:0]   OutFlag;
    logic         Valid;

    alu_flagged_n #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .En     (En),
        .FunSel (FunSel),
        .A      (A),
        .B      (B),
        .OutALU (OutALU),
        .OutFlag(OutFlag),
        .Valid  (Valid)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    logic [11:0] exp_q[$];
    logic [11:0] sb_e;
    logic [3:0]  m_flags;
    logic [7:0]  m_out;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: returns {O,N,C,Z, result}
    function automatic logic [11:0] model(input logic [3:0] fs, input logic [7:0] a,
                                          input logic [7:0] b, input logic [3:0] fl);
        logic       o, c;
        logic [7:0] r;
        int         s, sa, sb, sr;
        o  = fl[3];
        c  = fl[1];
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = a;
        case (fs)
            4'h0: r = a;
            4'h1: r = b;
            4'h2: r = ~a;
            4'h3: r = ~b;
            4'h4: begin
                s = int'(a) + int'(b); r = s[7:0]; c = (s > 255);
                sr = sa + sb; o = (sr > 127) || (sr < -128);
            end
            4'h5: begin
                s = int'(a) + int'(b) + int'(fl[1]); r = s[7:0]; c = (s > 255);
                sr = sa + sb + int'(fl[1]); o = (sr > 127) || (sr < -128);
            end
            4'h6: begin
                s = int'(a) - int'(b); r = s[7:0]; c = (a >= b);
                sr = sa - sb; o = (sr > 127) || (sr < -128);
            end
            4'h7: r = a & b;
            4'h8: r = a | b;
            4'h9: r = a ^ b;
            4'hA: begin r = a << 1; c = a[7]; end
            4'hB: begin r = a >> 1; c = a[0]; end
            4'hC: begin r = a << 1; o = a[7] ^ a[6]; end
            4'hD: r = 8'($signed(a) >>> 1);
            4'hE: begin r = {a[6:0], fl[1]}; c = a[7]; end
            default: begin r = {fl[1], a[7:1]}; c = a[0]; end
        endcase
        return {o, r[7], c, (r == 8'h00), r};
    endfunction

    // scoreboard: pop one expectation per Valid pulse
    always @(posedge CLK) begin
        #1;
        if (Valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_valid", 32'd1, 32'd0);
            end else begin
                sb_e = exp_q.pop_front();
                check_eq("sb_result", 32'(OutALU), 32'(sb_e[7:0]));
                check_eq("sb_flags", 32'(OutFlag), 32'(sb_e[11:8]));
            end
        end
    end

    // driver tasks
    task automatic op(input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b);
        logic [11:0] e;
        @(negedge CLK);
        En = 1'b1; FunSel = fs; A = a; B = b;
        e = model(fs, a, b, m_flags);
        exp_q.push_back(e);
        m_flags = e[11:8];
        m_out   = e[7:0];
        @(posedge CLK);
        #2;
        check_eq("op_valid", 32'(Valid), 32'd1);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic idle();
        @(negedge CLK);
        En = 1'b0; FunSel = 4'($urandom_range(0, 15));
        A = 8'($urandom_range(0, 255)); B = 8'($urandom_range(0, 255));
        @(posedge CLK);
        #2;
        check_eq("idle_valid", 32'(Valid), 32'd0);
        check_eq("idle_hold_out", 32'(OutALU), 32'(m_out));
        check_eq("idle_hold_flag", 32'(OutFlag), 32'(m_flags));
    endtask

    task automatic expect_out(input logic [7:0] r, input logic [3:0] f);
        check_eq("plan_out", 32'(OutALU), 32'(r));
        check_eq("plan_flag", 32'(OutFlag), 32'(f));
    endtask

    initial begin
        RST = 1'b1; En = 1'b0; FunSel = 4'h0; A = '0; B = '0;
        m_flags = 4'h0; m_out = 8'h00;
        #12;
        check_eq("rst_out", 32'(OutALU), 32'd0);
        check_eq("rst_flag", 32'(OutFlag), 32'd0);
        check_eq("rst_valid", 32'(Valid), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        op(4'h4, 8'h7F, 8'h01); expect_out(8'h80, 4'b1100);
        idle();                 expect_out(8'h80, 4'b1100);

        op(4'h4, 8'hFF, 8'h01); expect_out(8'h00, 4'b0011);
        op(4'h5, 8'h10, 8'h20); expect_out(8'h31, 4'b0000);

        op(4'h6, 8'h05, 8'h07); expect_out(8'hFE, 4'b0100);
        op(4'h6, 8'h07, 8'h05); expect_out(8'h02, 4'b0010);
        op(4'h6, 8'h80, 8'h01); expect_out(8'h7F, 4'b1010);

        op(4'hE, 8'h80, 8'h00); expect_out(8'h01, 4'b1010);
        op(4'hF, 8'h01, 8'h00); expect_out(8'h80, 4'b1110);
        op(4'hD, 8'h81, 8'h00); expect_out(8'hC0, 4'b1110);

        op(4'h7, 8'hF0, 8'h0F); expect_out(8'h00, 4'b1011);
        op(4'hC, 8'h40, 8'h00); expect_out(8'h80, 4'b1110);
        idle();

        // asynchronous reset between edges while Valid is still high
        op(4'h6, 8'h95, 8'h40); expect_out(8'h55, 4'b1010);
        @(negedge CLK);
        En = 1'b0;
        #2 RST = 1'b1;
        #1;
        check_eq("async_rst_out", 32'(OutALU), 32'd0);
        check_eq("async_rst_flag", 32'(OutFlag), 32'd0);
        check_eq("async_rst_valid", 32'(Valid), 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        check_eq("rst_held_valid", 32'(Valid), 32'd0);
        exp_q.delete();
        m_flags = 4'h0; m_out = 8'h00;
        @(negedge CLK);
        RST = 1'b0;
        op(4'h0, 8'h5A, 8'h00); expect_out(8'h5A, 4'b0000);

        // random traffic, mostly back-to-back
        repeat (300) begin
            if ($urandom_range(0, 3) != 0)
                op(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            else
                idle();
        end
        idle();
        check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_flagged_n.md
Name: alu_flagged_n

Overview:
- Parametrised-width successor to the 8-bit combinational ALU.
- Adds a registered result, a registered flag register {O,N,C,Z} and an input-enable/output-valid handshake.
- The carry-in for ADC and the rotate-through-carry ops is taken from the registered C flag.
- Sits between the operand muxes (MuxC/RegFile OutB) and the RF/ARF/Memory write paths of the datapath.

Parameters:
WIDTH, 8, operand/result width in bits (WIDTH >= 2)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  reset, asynchronous, active-high
En  input  1  operation request; sampled on rising CLK
FunSel  input  4  operation select (encoding below)
A  input  WIDTH  operand A
B  input  WIDTH  operand B
OutALU  output  WIDTH  registered result
OutFlag  output  4  registered flags {O,N,C,Z} = bits [3:0]
Valid  output  1  high for exactly one cycle after each accepted operation

Behaviour:
- Interface decided: one clock CLK; RST asynchronous, active-high.
- RST=1 at any time, including mid-stream: OutALU=0, OutFlag=4'b0000, Valid=0 immediately. No op is accepted while RST=1.
- Rising edge with En=1:
  - Result R is computed combinationally from A, B, FunSel and the current registered C.
  - R is latched to OutALU; flags update per the rules below; Valid=1.
  - Latency 1 cycle. Full throughput: back-to-back ops allowed, and each sees the flags of the previous op.
- Rising edge with En=0: OutALU and OutFlag hold; Valid=0.
- FunSel encoding:
  - 0: R=A
  - 1: R=B
  - 2: R=~A
  - 3: R=~B
  - 4: R=A+B
  - 5: R=A+B+C
  - 6: R=A-B, computed as A+~B+1
  - 7: R=A&B
  - 8: R=A|B
  - 9: R=A^B
  - A: LSL, R=A<<1, LSB 0
  - B: LSR, R=A>>1, MSB 0
  - C: ASL, R=A<<1
  - D: ASR, R={A[W-1],A[W-1:1]}
  - E: ROL through carry, R={A[W-2:0],C}
  - F: ROR through carry, R={C,A[W-1:1]}
- Z (bit 0) = (R==0). Updated on every accepted op.
- N (bit 2) = R[W-1]. Updated on every accepted op.
- C (bit 1), updated only on ops 4,5,6,A,B,E,F; held otherwise:
  - ops 4/5/6: carry-out of the WIDTH+1-bit sum. For SUB, C=1 means no borrow.
  - ops A and E: C=A[W-1].
  - ops B and F: C=A[0].
- O (bit 3), updated only on ops 4,5,6,C; held otherwise:
  - ops 4/5: O = (A[W-1]==B[W-1]) && (R[W-1]!=A[W-1]).
  - op 6: O = (A[W-1]!=B[W-1]) && (R[W-1]!=A[W-1]).
  - op C: O = A[W-1]^A[W-2].
- Flag updates and the OutALU load occur on the same edge; there are no partial updates.
- All arithmetic wraps modulo 2^WIDTH. There are no X/Z outputs after reset.

Test Plan (WIDTH=8):
- Assert RST asynchronously between edges after an op that left OutALU=0x55, flags=4'b1010 -> OutALU=0x00, OutFlag=0000, Valid=0 before the next edge; after release, the first En=1 edge gives Valid=1 one cycle later.
- En=1, FunSel=4, A=0x7F, B=0x01 -> next cycle OutALU=0x80, {O,N,C,Z}=1100, Valid=1; then En=0 with A/B changed -> OutALU=0x80 held, Valid=0.
- Back-to-back ADC: FunSel=4, A=0xFF, B=0x01 -> 0x00, flags 0011; next cycle FunSel=5, A=0x10, B=0x20 -> 0x31, flags 0000 (the carry from the previous op is consumed).
- SUB: A=0x05, B=0x07 -> 0xFE, C=0, N=1, O=0. Then A=0x07, B=0x05 -> 0x02, C=1, N=0. Then A=0x80, B=0x01 -> 0x7F, O=1, C=1.
- Rotates: with C=1, FunSel=E, A=0x80 -> 0x01, C=1. Then FunSel=F, A=0x01 -> 0x80, C=1, N=1. Then FunSel=D, A=0x81 -> 0xC0, C unchanged at 1.
- Flag hold: after a state with O=1, C=1, FunSel=7, A=0xF0, B=0x0F -> 0x00, Z=1, N=0, C=1 and O=1 retained. Then FunSel=C, A=0x40 -> 0x80, O=1, N=1, C=1 retained.
